gcd_control: RTL



---
 rtl/gcd_pkg.sv | 30 +++
 rtl/gcd_iter_counter.sv | 19 +
 rtl/gcd_control.sv | 87 ++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the Euclid-subtraction GCD controller.
package gcd_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] A_SEL_IN  = 2'd0;
    localparam logic [1:0] A_SEL_B   = 2'd1;
    localparam logic [1:0] A_SEL_SUB = 2'd2;
    localparam logic       B_SEL_IN  = 1'b0;
    localparam logic       B_SEL_A   = 1'b1;

    typedef struct packed {
        logic       a_en;
        logic       b_en;
        logic [1:0] a_mux_sel;
        logic       b_mux_sel;
    } dpath_ctrl_t;

    localparam dpath_ctrl_t CTRL_NONE = '{a_en: 1'b0, b_en: 1'b0, a_mux_sel: A_SEL_IN,  b_mux_sel: B_SEL_IN};
    localparam dpath_ctrl_t CTRL_LOAD = '{a_en: 1'b1, b_en: 1'b1, a_mux_sel: A_SEL_IN,  b_mux_sel: B_SEL_IN};
    localparam dpath_ctrl_t CTRL_SWAP = '{a_en: 1'b1, b_en: 1'b1, a_mux_sel: A_SEL_B,   b_mux_sel: B_SEL_A};
    localparam dpath_ctrl_t CTRL_SUB  = '{a_en: 1'b1, b_en: 1'b0, a_mux_sel: A_SEL_SUB, b_mux_sel: B_SEL_IN};

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating step counter; clear wins over increment, never wraps.
module gcd_iter_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/gcd_control.sv
// GCD controller: val/rdy wrapped load -> swap/subtract -> hold-result sequencing.
module gcd_control
    import gcd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             operands_val,
    output logic             operands_rdy,
    output logic             result_val,
    input  logic             result_rdy,
    input  logic             B_zero,
    input  logic             A_lt_B,
    output logic             A_en,
    output logic             B_en,
    output logic [1:0]       A_mux_sel,
    output logic             B_mux_sel,
    output logic [CNT_W-1:0] iter_count,
    output logic             busy
);

    state_t      state, state_nxt;
    dpath_ctrl_t ctrl;
    logic        accept;
    logic        step;

    // Outputs decode straight from state and status so a step costs no extra cycle.
    always_comb begin
        state_nxt    = state;
        ctrl         = CTRL_NONE;
        accept       = 1'b0;
        step         = 1'b0;
        operands_rdy = 1'b0;
        result_val   = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                operands_rdy = 1'b1;
                if (operands_val) begin
                    ctrl      = CTRL_LOAD;
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (A_lt_B) begin
                    ctrl = CTRL_SWAP;
                    step = 1'b1;
                end else if (!B_zero) begin
                    ctrl = CTRL_SUB;
                    step = 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                result_val = 1'b1;
                if (result_rdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign A_en      = ctrl.a_en;
    assign B_en      = ctrl.b_en;
    assign A_mux_sel = ctrl.a_mux_sel;
    assign B_mux_sel = ctrl.b_mux_sel;

    gcd_iter_counter #(.CNT_W(CNT_W)) u_iter_counter (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .inc   (step),
        .count (iter_count)
    );

endmodule
